// File: rtl/ps2_rx_event_fifo_if.sv
// ----------------------------------------------------------------------------
// ps2_rx_event_fifo_if
// Key-event stream between the PS/2 receive front end and its consumer.
//   ev_valid : head event present (FIFO non-empty)
//   ev_data  : head event {ext, brk, code[7:0]}
//   ev_ready : consumer takes the head event this cycle
//   ev_count : FIFO occupancy, 0 .. 2^FIFO_AW
// master = event source (receiver), slave = event consumer.
// ----------------------------------------------------------------------------
interface ps2_rx_event_fifo_if #(
  parameter int FIFO_AW = 4
) ();
  logic             ev_valid;
  logic [9:0]       ev_data;
  logic             ev_ready;
  logic [FIFO_AW:0] ev_count;

  modport master (output ev_valid, output ev_data, output ev_count, input ev_ready);
  modport slave  (input ev_valid, input ev_data, input ev_count, output ev_ready);
endinterface

// File: rtl/ps2_rx_event_fifo.sv
// ----------------------------------------------------------------------------
// ps2_rx_event_fifo
// PS/2 keyboard receive front end: synchronises and filters the pins,
// deserialises 11-bit device-to-host frames, folds E0/F0 prefixes into single
// key events, tracks shift/caps-lock, and queues events in a FWFT FIFO.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   ps2_clk_i         : raw PS/2 clock pin (asynchronous)
//   ps2_data_i        : raw PS/2 data pin (asynchronous)
//   ev                : event stream (valid/ready, head data, occupancy)
//   shift, capslock   : modifier state
//   frame_err         : 1-cycle pulse, bad start/parity/stop or timeout
//   overflow          : 1-cycle pulse, event dropped because FIFO was full
// ----------------------------------------------------------------------------
module ps2_rx_event_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_AW        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk_i,
  input  logic                       ps2_data_i,
  ps2_rx_event_fifo_if.master        ev,
  output logic                       shift,
  output logic                       capslock,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam int               FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [7:0]       CODE_EXT   = 8'hE0;
  localparam logic [7:0]       CODE_BRK   = 8'hF0;
  localparam logic [7:0]       CODE_LSHFT = 8'h12;
  localparam logic [7:0]       CODE_RSHFT = 8'h59;
  localparam logic [7:0]       CODE_CAPS  = 8'h58;

  // Pin conditioning
  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_clk_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             flip, fall_edge;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample;
  // a flip from high is the falling edge that samples data.
  assign flip      = (clk_s2_q != filt_clk_q) && (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
  assign fall_edge = flip && filt_clk_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop updates from
    // pre-edge values; blocking assignments here would chain the synchroniser.
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      if (clk_s2_q == filt_clk_q) begin
        flt_cnt_q <= '0;
      end else if (flip) begin
        filt_clk_q <= clk_s2_q;
        flt_cnt_q  <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_W'(1);
      end
    end
  end

  // Deserialiser and timeout
  logic [3:0]      bit_cnt_q;
  logic [9:0]      frame_q;    // {parity, data[7:0], start}
  logic [TO_W-1:0] idle_q;
  logic            byte_valid_q, frame_err_q;
  logic [7:0]      byte_q;
  logic            frame_ok;

  assign frame_ok = !frame_q[0] && dat_s2_q && (^frame_q[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      frame_q      <= '0;
      idle_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_q       <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall_edge) begin
        idle_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (frame_ok) begin
            byte_valid_q <= 1'b1;
            byte_q       <= frame_q[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          frame_q[bit_cnt_q] <= dat_s2_q;
          bit_cnt_q          <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (idle_q == TO_W'(TIMEOUT_CYCLES)) begin
          bit_cnt_q   <= '0;
          idle_q      <= '0;
          frame_err_q <= 1'b1;
        end else begin
          idle_q <= idle_q + TO_W'(1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  // Decoder, modifiers and FIFO control
  logic               ext_q, brk_q;
  logic               held_l_q, held_r_q, caps_q, caps_held_q;
  logic               overflow_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [9:0]         mem_q [DEPTH];
  logic               push_req, push_ok, pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    push_req = 1'b0;
    if (byte_valid_q && byte_q != CODE_EXT && byte_q != CODE_BRK) push_req = 1'b1;
    pop     = (count_q != '0) && ev.ev_ready;
    push_ok = push_req && ((count_q < DEPTH_C) || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_l_q    <= 1'b0;
      held_r_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      overflow_q <= push_req && !push_ok;
      if (frame_err_q || push_req) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (byte_q == CODE_EXT) ext_q <= 1'b1;
        if (byte_q == CODE_BRK) brk_q <= 1'b1;
      end
      // Modifiers follow every emitted non-extended event, even a dropped one.
      if (push_req && !ext_q) begin
        case (byte_q)
          CODE_LSHFT: held_l_q <= !brk_q;
          CODE_RSHFT: held_r_q <= !brk_q;
          CODE_CAPS: begin
            if (!brk_q && !caps_held_q) caps_q <= !caps_q;
            caps_held_q <= !brk_q;
          end
          default: ;
        endcase
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is defined by the pointers and count,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ext_q, brk_q, byte_q};
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_data  = mem_q[rd_ptr_q];
  assign ev.ev_count = count_q;
  assign shift       = held_l_q | held_r_q;
  assign capslock    = caps_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_event_fifo
// Drives PS/2 frames into ps2_rx_event_fifo and compares the event stream,
// modifiers and error pulses against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_ps2_rx_event_fifo;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 200;
  localparam int FIFO_AW    = 4;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int H          = 20;   // PS/2 half bit period in system clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic shift, capslock, frame_err, overflow;

  ps2_rx_event_fifo_if #(.FIFO_AW(FIFO_AW)) ev_if ();

  ps2_rx_event_fifo #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_AW       (FIFO_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .ev        (ev_if),
    .shift     (shift),
    .capslock  (capslock),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key-event semantics at the byte level
  logic [9:0] exp_q[$];
  bit m_ext, m_brk, m_hl, m_hr, m_caps, m_caps_held;
  int exp_ferr = 0, exp_ovf = 0;
  int ferr_cnt = 0, ovf_cnt = 0;
  int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_hl = 0; m_hr = 0; m_caps = 0; m_caps_held = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext) begin
        if (b == 8'h12) m_hl = !m_brk;
        if (b == 8'h59) m_hr = !m_brk;
        if (b == 8'h58) begin
          if (!m_brk && !m_caps_held) m_caps = !m_caps;
          m_caps_held = !m_brk;
        end
      end
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf++;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Monitor: sampled on the falling system-clock edge
  always @(negedge clk) begin
    if (!rst) begin
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (exp_q.size() == 0) check("spurious_event", ev_if.ev_valid, 0);
        else check("ev_data", ev_if.ev_data, exp_q.pop_front());
      end
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
    end
  end

  // Consumer ready, changed just after the active edge
  initial begin
    ev_if.ev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ev_if.ev_ready = 1'b0;
        1:       ev_if.ev_ready = 1'b1;
        default: ev_if.ev_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    wait_cyc(H);
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(1'b1);
    wait_cyc(H);
  endtask

  task automatic check_mods();
    check("shift", shift, m_hl | m_hr);
    check("capslock", capslock, m_caps);
  endtask

  task automatic do_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b0);
    check_mods();
  endtask

  task automatic do_bad(input logic [7:0] b);
    m_ext = 0;
    m_brk = 0;
    exp_ferr++;
    send_frame(b, 1'b1);
    check_mods();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    model_reset();
    wait_cyc(4);
    check("rst_ev_valid", ev_if.ev_valid, 0);
    check("rst_ev_count", ev_if.ev_count, 0);
    check("rst_shift", shift, 0);
    check("rst_capslock", capslock, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    rdy_mode = 1;
    wait_cyc(4);

    // Plain make code, then prefixed break
    do_byte(8'h1C);
    check("ferr_after_1c", ferr_cnt, 0);
    do_byte(8'hE0);
    do_byte(8'hF0);
    do_byte(8'h75);
    do_byte(8'h1C);
    drain();

    // Parity error then good frame
    do_bad(8'h1C);
    check("ferr_parity", ferr_cnt, exp_ferr);
    do_byte(8'h29);

    // Caps lock and shift
    do_byte(8'h58);
    check("caps_first_make", capslock, 1);
    do_byte(8'h58);
    do_byte(8'hF0);
    do_byte(8'h58);
    check("caps_after_break", capslock, 1);
    do_byte(8'h58);
    check("caps_second_press", capslock, 0);
    do_byte(8'h12);
    check("shift_make", shift, 1);
    do_byte(8'hF0);
    do_byte(8'h12);
    check("shift_break", shift, 0);
    drain();

    // Timeout with a pending prefix, then a clean frame
    do_byte(8'hE0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    wait_cyc(TIMEOUT + 10);
    exp_ferr++;
    m_ext = 0;
    m_brk = 0;
    check("ferr_timeout", ferr_cnt, exp_ferr);
    do_byte(8'h1C);

    // Short clock glitch must not count as a bit
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(2 * H);
    do_byte(8'h1C);
    check("ferr_glitch", ferr_cnt, exp_ferr);
    drain();

    // Overflow: fill with consumer stalled, then drain in order
    rdy_mode = 0;
    wait_cyc(4);
    for (int k = 1; k <= 17; k++) do_byte(8'(k));
    check("ovf_ev_count", ev_if.ev_count, DEPTH);
    check("ovf_ev_valid", ev_if.ev_valid, 1);
    check("ovf_pulses", ovf_cnt, exp_ovf);
    rdy_mode = 1;
    drain();
    wait_cyc(2);
    check("drained_count", ev_if.ev_count, 0);

    // Reset in the middle of a frame with modifiers and a prefix pending
    do_byte(8'h12);
    do_byte(8'hE0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    wait_cyc(3);
    model_reset();
    check("midrst_shift", shift, 0);
    check("midrst_ev_count", ev_if.ev_count, 0);
    check("midrst_frame_err", frame_err, 0);
    ps2_data = 1'b1;
    rst = 1'b0;
    wait_cyc(4);
    do_byte(8'h1C);
    drain();

    // Randomised byte stream with a randomly stalling consumer
    rdy_mode = 2;
    for (int n = 0; n < 50; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: do_byte(8'hE0);
        1: do_byte(8'hF0);
        2: do_byte(8'h12);
        3: do_byte(8'h59);
        4: do_byte(8'h58);
        5: do_bad(8'($urandom_range(1, 8'h83)));
        default: do_byte(8'($urandom_range(1, 8'h83)));
      endcase
    end
    rdy_mode = 1;
    drain();
    wait_cyc(4);
    check("final_ev_valid", ev_if.ev_valid, 0);
    check("final_frame_errs", ferr_cnt, exp_ferr);
    check("final_overflows", ovf_cnt, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_event_fifo.md
# ps2_rx_event_fifo

Parametrised PS/2 keyboard receive front end: filters and deserialises device-to-host frames, decodes scan-code set 2 prefixes (E0 extended, F0 break) into single key events, tracks shift/caps-lock state, and buffers events in a first-word-fall-through FIFO with valid/ready handshake. It sits between the PS/2 pins and the LCD/display logic. It replaces the fixed single-register key path with a configurable filter, timeout and event queue. Receive only; the host never drives the PS/2 lines.

## Interface
- FILTER_LEN, 8, consecutive identical synchronised samples required to accept a ps2_clk level change (≥2)
- TIMEOUT_CYCLES, 50000, idle cycles within a partial frame before it is discarded
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous
- ps2_data_i  in  1  raw PS/2 data pin, asynchronous
- ev_valid  out  1  FIFO non-empty
- ev_data  out  10  head event {ext, brk, code[7:0]}
- ev_ready  in  1  consumer accepts head this cycle
- ev_count  out  FIFO_AW+1  FIFO occupancy
- shift  out  1  left (0x12) or right (0x59) shift held
- capslock  out  1  caps-lock toggle state
- frame_err  out  1  one-cycle pulse: bad start/parity/stop, or timeout
- overflow  out  1  one-cycle pulse: event dropped, FIFO full

## Operation
- Input conditioning: both pins pass a 2-flop synchroniser, reset value 1. The filtered clock resets to 1. It changes only after FILTER_LEN consecutive synchronised samples differ from its current value. A falling edge of the filtered clock samples the synchronised data.
- Deserialiser: 11 bits per frame: start 0, data bits 0..7 LSB first, odd parity, stop 1. A bit counter of 0..10 counts the bits.
  - After the stop bit, a good frame produces byte_valid for one cycle.
  - A frame with any check failure asserts frame_err and produces no byte.
  - The counter returns to 0 after every frame, good or bad.
- Timeout: if the bit counter is nonzero and no filtered falling edge occurs for TIMEOUT_CYCLES cycles, the partial frame is dropped, the counter is cleared, and frame_err pulses.
- Decoder flags: ext and brk, both 0 at reset.
  - Byte 0xE0 sets ext.
  - Byte 0xF0 sets brk.
  - Any other byte emits event {ext, brk, byte}, then clears both flags.
  - A frame error also clears both flags.
  - Prefix bytes are never enqueued.
- Modifiers: updated on every emitted event with ext=0. Events that change modifiers are still enqueued.
  - shift = held(0x12) OR held(0x59). Make sets held; break clears it.
  - capslock toggles on a make of 0x58 only when caps_held=0. Then caps_held is set; break of 0x58 clears caps_held. Typematic repeats therefore do not toggle.
- FIFO push rule: a push is accepted if ev_count < depth or a pop occurs the same cycle. Otherwise the event is dropped and overflow pulses.
- FIFO pop rule: pop occurs when ev_valid && ev_ready. ev_data always presents the head; it is don't-care when empty.
- Simultaneous push and pop: ev_count is unchanged. Read and write pointers wrap modulo depth.
- Reset mid-frame: discards the partial frame, flags, FIFO contents and modifiers immediately.

## Timing
- Reset values: ev_valid=0, ev_count=0, shift=0, capslock=0, frame_err=0, overflow=0. ev_data is don't-care.
- Pin to filtered edge: 2 + FILTER_LEN cycles.
- Stop bit sampled in cycle T; byte_valid is registered in T+1; the event is written at the end of T+1.
- ev_valid, updated ev_count, shift and capslock are visible in T+2.
- frame_err is visible in T+1; overflow is visible in T+2.
- A timeout frame_err is asserted in the cycle after the idle counter reaches TIMEOUT_CYCLES.
- ev_count and ev_valid update on the cycle after a pop.

## Test plan
- Frame 0x1C (parity 0, odd) with ev_ready=1 → ev_valid for 1 cycle with ev_data=0x01C; shift=0; no frame_err.
- Bytes E0, F0, 75 → exactly one event, ev_data=0x375; flags cleared afterwards (next 0x1C gives 0x01C).
- Frame 0x1C with parity bit 1 → frame_err pulse, no event; following good 0x29 → 0x029.
- Caps sequence:
  - 58, 58, F0 58 → three events 0x058, 0x058, 0x158; capslock=1 after the first and stays 1.
  - A second 58 → capslock=0.
  - 12 then F0 12 → shift 1 then 0.
- Overflow: ev_ready=0, FIFO_AW=4, 17 make codes 0x01..0x11 → ev_count=16, one overflow pulse on the 17th. Then with ev_ready=1, drains 0x001..0x010 in order.
- Timeout and glitch:
  - 5 bits, then the clock held high for TIMEOUT_CYCLES+10 cycles → frame_err; next full frame 0x1C decodes as 0x01C.
  - A ps2_clk low pulse of FILTER_LEN−1 cycles is ignored (no bit counted).
